// File: rtl/maquina_estados_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maquina_estados_pkg
//  Description : State and request codes shared by the elevator controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package maquina_estados_pkg;

    localparam int unsigned C_STATE_W  = 4;
    localparam int unsigned C_ACCION_W = 2;

    // Controller state codes; codes 6..15 are illegal and recover to REPOSO
    typedef enum logic [C_STATE_W-1:0] {
        REPOSO = 4'd0,
        SUBIR  = 4'd1,
        BAJAR  = 4'd2,
        FRENAR = 4'd3,
        ABRIR  = 4'd4,
        CERRAR = 4'd5
    } estado_t;

    // Requests issued by the floor/request verifier
    typedef enum logic [C_ACCION_W-1:0] {
        NINGUNA = 2'b00,
        SUBE    = 2'b01,
        BAJA    = 2'b10,
        LLEGO   = 2'b11
    } accion_t;

endpackage : maquina_estados_pkg
`default_nettype wire

// File: rtl/maquina_estados.sv
`default_nettype none
// ============================================================================
//  Module      : maquina_estados
//  Description : Elevator cabin controller. One state register with
//                next-state decode and Moore-style output decode (outputs
//                depend only on the registered state and the two door
//                sensors, never on accion or t_expired).
//  Revision    : 1.0 - initial release
// ============================================================================
module maquina_estados
    import maquina_estados_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] accion,
    input  logic       sensor_puerta,
    input  logic       sensor_sobrepeso,
    input  logic       t_expired,
    output logic [3:0] state,
    output logic       restart_timer,
    output logic       start_timer,
    output logic       habilita_verificador,
    output logic       inicia_Registro_Solicitudes,
    output logic       subiendo_LED,
    output logic       bajando_LED,
    output logic       freno_act_LED,
    output logic       motor_act_LED,
    output logic       puerta_abierta_LED,
    output logic       puerta_cerrada_LED,
    output logic       sensor_puerta_LED,
    output logic       sensor_sobrepeso_LED,
    output logic       ready
);

    estado_t state_q;
    estado_t state_d;
    logic    w_sensor_any;

    assign w_sensor_any = sensor_puerta | sensor_sobrepeso;
    assign state        = state_q;

    // State register; reset returns the cabin to REPOSO without waiting for clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= REPOSO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a moving cabin only reacts to "floor reached"
    always_comb begin
        state_d = state_q;
        case (state_q)
            REPOSO: begin
                case (accion_t'(accion))
                    SUBE:    state_d = SUBIR;
                    BAJA:    state_d = BAJAR;
                    LLEGO:   state_d = FRENAR;
                    default: state_d = REPOSO;
                endcase
            end
            SUBIR, BAJAR: begin
                if (accion_t'(accion) == LLEGO) begin
                    state_d = FRENAR;
                end
            end
            FRENAR: state_d = ABRIR;
            ABRIR: begin
                // An obstruction or overload keeps the door open even if the timer ran out
                if (!w_sensor_any && t_expired) begin
                    state_d = CERRAR;
                end
            end
            CERRAR: begin
                state_d = w_sensor_any ? ABRIR : REPOSO;
            end
            default: state_d = REPOSO;
        endcase
    end

    // Output decode from registered state plus live door sensors
    always_comb begin
        restart_timer               = 1'b0;
        start_timer                 = 1'b0;
        habilita_verificador        = 1'b0;
        inicia_Registro_Solicitudes = 1'b0;
        subiendo_LED                = 1'b0;
        bajando_LED                 = 1'b0;
        freno_act_LED               = 1'b1;
        motor_act_LED               = 1'b0;
        puerta_abierta_LED          = 1'b0;
        puerta_cerrada_LED          = 1'b1;
        sensor_puerta_LED           = 1'b0;
        sensor_sobrepeso_LED        = 1'b0;
        ready                       = 1'b0;
        case (state_q)
            REPOSO: begin
                ready                = 1'b1;
                habilita_verificador = 1'b1;
            end
            SUBIR: begin
                habilita_verificador = 1'b1;
                subiendo_LED         = 1'b1;
                motor_act_LED        = 1'b1;
                freno_act_LED        = 1'b0;
            end
            BAJAR: begin
                habilita_verificador = 1'b1;
                bajando_LED          = 1'b1;
                motor_act_LED        = 1'b1;
                freno_act_LED        = 1'b0;
            end
            FRENAR: begin
                inicia_Registro_Solicitudes = 1'b1;
                restart_timer               = 1'b1;
            end
            ABRIR: begin
                puerta_abierta_LED   = 1'b1;
                puerta_cerrada_LED   = 1'b0;
                restart_timer        = w_sensor_any;
                start_timer          = !w_sensor_any;
                sensor_puerta_LED    = sensor_puerta;
                sensor_sobrepeso_LED = sensor_sobrepeso;
            end
            CERRAR: begin
                sensor_puerta_LED    = sensor_puerta;
                sensor_sobrepeso_LED = sensor_sobrepeso;
            end
            default: begin
            end
        endcase
    end

endmodule : maquina_estados
`default_nettype wire

// File: tb/tb_maquina_estados.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maquina_estados
//  Description : Directed self-checking bench for the elevator controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maquina_estados;

    logic       clk;
    logic       reset;
    logic [1:0] accion;
    logic       sensor_puerta;
    logic       sensor_sobrepeso;
    logic       t_expired;
    logic [3:0] state;
    logic       restart_timer, start_timer, habilita_verificador;
    logic       inicia_Registro_Solicitudes, subiendo_LED, bajando_LED;
    logic       freno_act_LED, motor_act_LED, puerta_abierta_LED;
    logic       puerta_cerrada_LED, sensor_puerta_LED, sensor_sobrepeso_LED;
    logic       ready;

    int tests  = 0;
    int failed = 0;

    // Output bundle, MSB first:
    // restart, start, habilita, inicia, subiendo, bajando, freno, motor,
    // p_abierta, p_cerrada, s_puerta_LED, s_sobrepeso_LED, ready
    logic [12:0] outs;
    assign outs = {restart_timer, start_timer, habilita_verificador,
                   inicia_Registro_Solicitudes, subiendo_LED, bajando_LED,
                   freno_act_LED, motor_act_LED, puerta_abierta_LED,
                   puerta_cerrada_LED, sensor_puerta_LED,
                   sensor_sobrepeso_LED, ready};

    localparam logic [12:0] C_O_REPOSO   = 13'b0_0_1_0_0_0_1_0_0_1_0_0_1;
    localparam logic [12:0] C_O_SUBIR    = 13'b0_0_1_0_1_0_0_1_0_1_0_0_0;
    localparam logic [12:0] C_O_BAJAR    = 13'b0_0_1_0_0_1_0_1_0_1_0_0_0;
    localparam logic [12:0] C_O_FRENAR   = 13'b1_0_0_1_0_0_1_0_0_1_0_0_0;
    localparam logic [12:0] C_O_ABRIR    = 13'b0_1_0_0_0_0_1_0_1_0_0_0_0;
    localparam logic [12:0] C_O_ABRIR_SP = 13'b1_0_0_0_0_0_1_0_1_0_1_0_0;
    localparam logic [12:0] C_O_ABRIR_SO = 13'b1_0_0_0_0_0_1_0_1_0_0_1_0;
    localparam logic [12:0] C_O_CERRAR   = 13'b0_0_0_0_0_0_1_0_0_1_0_0_0;
    localparam logic [12:0] C_O_CERR_SP  = 13'b0_0_0_0_0_0_1_0_0_1_1_0_0;

    maquina_estados u_dut (
        .clk                         (clk),
        .reset                       (reset),
        .accion                      (accion),
        .sensor_puerta               (sensor_puerta),
        .sensor_sobrepeso            (sensor_sobrepeso),
        .t_expired                   (t_expired),
        .state                       (state),
        .restart_timer               (restart_timer),
        .start_timer                 (start_timer),
        .habilita_verificador        (habilita_verificador),
        .inicia_Registro_Solicitudes (inicia_Registro_Solicitudes),
        .subiendo_LED                (subiendo_LED),
        .bajando_LED                 (bajando_LED),
        .freno_act_LED               (freno_act_LED),
        .motor_act_LED               (motor_act_LED),
        .puerta_abierta_LED          (puerta_abierta_LED),
        .puerta_cerrada_LED          (puerta_cerrada_LED),
        .sensor_puerta_LED           (sensor_puerta_LED),
        .sensor_sobrepeso_LED        (sensor_sobrepeso_LED),
        .ready                       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_state(input string tag, input logic [3:0] exp);
        tests++;
        assert (state === exp) else begin
            failed++;
            $error("FAIL %s: state observed %0d expected %0d", tag, state, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [12:0] exp);
        tests++;
        assert (outs === exp) else begin
            failed++;
            $error("FAIL %s: outputs observed %b expected %b", tag, outs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; accion = 2'b00; sensor_puerta = 1'b0;
        sensor_sobrepeso = 1'b0; t_expired = 1'b0;

        // Under reset
        #2;
        chk_state("rst_state", 4'd0);
        chk_outs ("rst_outs", C_O_REPOSO);
        #10 reset = 1'b1;
        tick();
        chk_state("idle_state", 4'd0);
        chk_outs ("idle_outs", C_O_REPOSO);

        // Sensor LEDs stay dark outside the door states
        sensor_puerta = 1'b1; #1;
        chk_outs("idle_sensor_masked", C_O_REPOSO);
        sensor_puerta = 1'b0;

        // Go down; reversal and idle requests are ignored while moving
        accion = 2'b10; tick();
        chk_state("down_state", 4'd2);
        chk_outs ("down_outs", C_O_BAJAR);
        accion = 2'b01; tick();
        chk_state("down_no_reverse", 4'd2);
        accion = 2'b00; tick();
        chk_state("down_hold", 4'd2);
        chk_outs ("down_hold_outs", C_O_BAJAR);

        // Floor reached: one brake cycle then door opens
        accion = 2'b11; tick();
        chk_state("brake_state", 4'd3);
        chk_outs ("brake_outs", C_O_FRENAR);
        accion = 2'b00; tick();
        chk_state("open_state", 4'd4);
        chk_outs ("open_outs", C_O_ABRIR);

        // Obstruction / overload outrank an expired timer
        sensor_puerta = 1'b1; t_expired = 1'b1; #1;
        chk_outs("open_obstr_outs", C_O_ABRIR_SP);
        tick();
        chk_state("open_obstr_stay", 4'd4);
        sensor_puerta = 1'b0; sensor_sobrepeso = 1'b1; #1;
        chk_outs("open_over_outs", C_O_ABRIR_SO);
        tick();
        chk_state("open_over_stay", 4'd4);

        // Clear sensors, timer expired: close then idle
        sensor_sobrepeso = 1'b0; #1;
        chk_outs("open_clear_outs", C_O_ABRIR);
        tick();
        chk_state("close_state", 4'd5);
        chk_outs ("close_outs", C_O_CERRAR);
        t_expired = 1'b0; tick();
        chk_state("back_idle", 4'd0);
        chk_outs ("back_idle_outs", C_O_REPOSO);

        // Timer not expired keeps door open; obstruction while closing reopens
        accion = 2'b11; tick();
        chk_state("brake2_state", 4'd3);
        accion = 2'b00; tick();
        tick();
        chk_state("open_no_timer", 4'd4);
        t_expired = 1'b1; tick();
        chk_state("close2_state", 4'd5);
        t_expired = 1'b0; sensor_puerta = 1'b1; #1;
        chk_outs("close_obstr_outs", C_O_CERR_SP);
        tick();
        chk_state("reopen_state", 4'd4);
        sensor_puerta = 1'b0; t_expired = 1'b1; tick();
        t_expired = 1'b0; tick();
        chk_state("idle_again", 4'd0);

        // Go up; down request ignored, then asynchronous reset mid-travel
        accion = 2'b01; tick();
        chk_state("up_state", 4'd1);
        chk_outs ("up_outs", C_O_SUBIR);
        accion = 2'b10; tick();
        chk_state("up_no_reverse", 4'd1);
        #2 reset = 1'b0;
        #1;
        chk_state("async_rst_state", 4'd0);
        chk_outs ("async_rst_outs", C_O_REPOSO);
        accion = 2'b00;
        #3 reset = 1'b1;
        tick();
        chk_state("post_rst_idle", 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_maquina_estados
`default_nettype wire
